// File: rtl/instruction_fetch_unit_pkg.sv
// ============================================================================
// Module  : instruction_fetch_unit_pkg
// Brief   : Shared defaults, opcode field layout and FSM encoding for fetch.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package instruction_fetch_unit_pkg;

    localparam int          C_ADDR_W    = 8;
    localparam int          C_INSTR_W   = 32;
    localparam int          C_CNT_W     = 16;
    localparam int          C_RESET_PC  = 0;
    localparam logic [5:0]  C_HALT_OP   = 6'h3F;
    localparam int          C_OPC_W     = 6;    // opcode occupies [INSTR_W-1 -: 6], i.e. [31:26]

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/instruction_fetch_unit.sv
// ============================================================================
// Module  : instruction_fetch_unit
// Brief   : PC owner and IF/ID register with decode handshake, redirect flush
//           and sticky HALT on the reserved opcode.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch_unit
    import instruction_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = C_ADDR_W,
    parameter int                INSTR_W  = C_INSTR_W,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(C_RESET_PC),
    parameter logic [5:0]        HALT_OP  = C_HALT_OP,
    parameter int                CNT_W    = C_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    output logic [ADDR_W-1:0]  Address,
    input  logic [INSTR_W-1:0] InstructionIn,
    input  logic               IdReady,
    input  logic               Redirect,
    input  logic [ADDR_W-1:0]  RedirectTarget,
    output logic               IfIdValid,
    output logic [INSTR_W-1:0] IfIdInstr,
    output logic [ADDR_W-1:0]  IfIdPcPlus4,
    output logic               Halted,
    output logic [CNT_W-1:0]   FetchCount
);

    fetch_state_e       r_state_q,   w_state_d;
    logic [ADDR_W-1:0]  r_pc_q,      w_pc_d;
    logic               r_valid_q,   w_valid_d;
    logic [INSTR_W-1:0] r_instr_q,   w_instr_d;
    logic [ADDR_W-1:0]  r_pcp4_q,    w_pcp4_d;
    logic [CNT_W-1:0]   r_cnt_q,     w_cnt_d;

    logic               w_accept;
    logic               w_halt_hit;
    logic [ADDR_W-1:0]  w_pc_plus4;

    assign w_accept   = (r_state_q == ST_RUN) && (!r_valid_q || IdReady);
    assign w_halt_hit = (InstructionIn[INSTR_W-1 -: C_OPC_W] == HALT_OP);
    assign w_pc_plus4 = r_pc_q + ADDR_W'(4);   // wraps modulo 2^ADDR_W

    always_comb begin
        w_state_d = r_state_q;
        w_pc_d    = r_pc_q;
        w_valid_d = r_valid_q;
        w_instr_d = r_instr_q;
        w_pcp4_d  = r_pcp4_q;
        w_cnt_d   = r_cnt_q;

        if (Redirect) begin
            // Redirect wins over everything but reset and also releases HALT
            w_pc_d    = {RedirectTarget[ADDR_W-1:2], 2'b00};
            w_valid_d = 1'b0;
            w_state_d = ST_RUN;
        end else if (r_state_q == ST_RUN) begin
            if (w_accept) begin
                if (w_halt_hit) begin
                    w_state_d = ST_HALT;
                    w_valid_d = 1'b0;
                end else begin
                    w_instr_d = InstructionIn;
                    w_pcp4_d  = w_pc_plus4;
                    w_valid_d = 1'b1;
                    w_pc_d    = w_pc_plus4;
                    if (!(&r_cnt_q)) begin
                        w_cnt_d = r_cnt_q + CNT_W'(1);
                    end
                end
            end
        end else begin
            if (r_valid_q && IdReady) begin
                w_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= ST_RUN;
            r_pc_q    <= RESET_PC;
            r_valid_q <= 1'b0;
            r_instr_q <= '0;
            r_pcp4_q  <= '0;
            r_cnt_q   <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_pc_q    <= w_pc_d;
            r_valid_q <= w_valid_d;
            r_instr_q <= w_instr_d;
            r_pcp4_q  <= w_pcp4_d;
            r_cnt_q   <= w_cnt_d;
        end
    end

    assign Address     = r_pc_q;
    assign IfIdValid   = r_valid_q;
    assign IfIdInstr   = r_instr_q;
    assign IfIdPcPlus4 = r_pcp4_q;
    assign Halted      = (r_state_q == ST_HALT);
    assign FetchCount  = r_cnt_q;

endmodule

`default_nettype wire
